// File: rtl/mux8x1_rr_ctrl_pkg.sv
// Shared types and constants for the round-robin controller around the 8:1 bit mux.
package mux8x1_rr_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int MAX_HOLD_DEF = 15;
  localparam int HOLD_W_DEF   = 4;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8x1_rr_ctrl_if.sv
// Requester-side bundle: requests, release strobe and data in, grant/select/status out.
interface mux8x1_rr_ctrl_if;
  import mux8x1_rr_ctrl_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] i;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             gnt_valid;
  logic             timeout;
  logic             y;

  modport master (
    output req, done, i,
    input  gnt, sel, gnt_valid, timeout, y
  );

  modport slave (
    input  req, done, i,
    output gnt, sel, gnt_valid, timeout, y
  );
endinterface

// File: rtl/mux8x1.sv
// Plain 8:1 bit-select datapath shared among the requesters.
module mux8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

// File: rtl/mux8x1_rr_ctrl_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod 8.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);
  // Scan from the farthest position back toward ptr so the nearest hit wins.
  always_comb begin
    logic [2:0] pos;
    any = |req;
    idx = 3'd0;
    pos = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      pos = ptr + 3'(k);
      if (req[pos]) begin
        idx = pos;
      end else begin
        idx = idx;
      end
    end
  end
endmodule

// File: rtl/mux8x1_rr_ctrl.sv
// Round-robin owner FSM for the shared mux8x1: registered grant/select, hold limit
// with timeout pulse, and a gated combinational data bit.
module mux8x1_rr_ctrl
  import mux8x1_rr_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mux8x1_rr_ctrl_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              timeout_q, timeout_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic              mux_y;
  logic              release_c;
  logic              expire_c;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  mux8x1 u_mux (
    .i (bus.i),
    .s (sel_q),
    .y (mux_y)
  );

  // Release wins over the hold limit when both land on the same cycle.
  assign release_c = bus.done | ~bus.req[sel_q];
  assign expire_c  = ~release_c & (hold_q == HOLD_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot8(pick_idx);
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          gnt_d   = {N_REQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (release_c || expire_c) begin
          state_d   = ST_IDLE;
          gnt_d     = {N_REQ{1'b0}};
          ptr_d     = sel_q + 3'd1;
          timeout_d = expire_c;
        end else begin
          hold_d    = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {N_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= {HOLD_W{1'b0}};
      gnt_q     <= {N_REQ{1'b0}};
      sel_q     <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = (state_q == ST_GRANT);
  assign bus.timeout   = timeout_q;
  assign bus.y         = mux_y & (state_q == ST_GRANT);

endmodule
